i2c_target: RTL and testbench

I2C responder (slave) for the lab I2C bus: the opposite end of the team's I2C controller that sends address byte 8'b10010011. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs, accepts write bytes and returns a 16-bit read word MSB-first. It is used as a TMP101 stand-in for bench and on-board loopback against the controller.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_target_if.sv | 30 +++
 rtl/i2c_line_sync.sv | 60 ++++++
 rtl/i2c_target.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK bit levels and the
// default lab target address, common to the controller and the target.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WRITE,
      WRITE_ACK,
      READ,
      READ_ACK,
      WAIT_STOP
   } i2c_state_e;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   localparam logic [6:0] DEFAULT_ADDR = 7'b1001001;

endpackage

// File: rtl/i2c_target_if.sv
// Bus-side signal bundle of the I2C target (SCL sense plus register-side data).
// SDA stays a plain inout on the target so open-drain resolution happens at the pin.
interface i2c_target_if;

   logic        SCL;
   logic [15:0] TxData;
   logic [7:0]  RxData;
   logic        RxValid;
   logic        AddrMatch;
   logic        Busy;

   modport slave (
      input  SCL,
      input  TxData,
      output RxData,
      output RxValid,
      output AddrMatch,
      output Busy
   );

   modport master (
      output SCL,
      output TxData,
      input  RxData,
      input  RxValid,
      input  AddrMatch,
      input  Busy
   );

endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer with rise/fall pulse outputs for one I2C line.
// Define I2C_TARGET_GLITCH_FILTER_EN to insert a 3-sample majority filter before edge detection.
module i2c_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;
   logic       level;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [1:0] hist_q, hist_d;

   // Majority of the current and two previous synchronized samples.
   always_comb begin
      hist_d = {hist_q[0], sync_q[1]};
      level  = (sync_q[1] & hist_q[0]) |
               (sync_q[1] & hist_q[1]) |
               (hist_q[0] & hist_q[1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '1;
      end else begin
         hist_q <= hist_d;
      end
   end
`else
   always_comb begin
      level = sync_q[1];
   end
`endif

   always_comb begin
      sync_d = {sync_q[0], line_i};
      prev_d = level;
   end

   // Lines idle high, so reset to 1 to avoid a false edge on release.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level_o = level;
   assign rise_o  = level & ~prev_q;
   assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, ACK, unlimited write bytes, repeating 16-bit read word.
// Optional glitch filter on both lines via I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] SlaveAddress = DEFAULT_ADDR
) (
   input  logic        clock,
   input  logic        Reset,
   inout  wire         SDA,
   i2c_target_if.slave bus
);

   logic scl_level, scl_rise, scl_fall;
   logic sda_level, sda_rise, sda_fall;
   logic start_det, stop_det;
   logic [7:0] rx_byte;

   i2c_state_e  state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [15:0] tx_q, tx_d;
   logic        rw_q, rw_d;
   logic        phase_q, phase_d;
   logic        byte_lo_q, byte_lo_d;
   logic        sda_low_q, sda_low_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        addr_match_q, addr_match_d;
   logic        busy_q, busy_d;

   i2c_line_sync u_scl_sync (
      .clk     (clock),
      .rst     (Reset),
      .line_i  (bus.SCL),
      .level_o (scl_level),
      .rise_o  (scl_rise),
      .fall_o  (scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .clk     (clock),
      .rst     (Reset),
      .line_i  (SDA),
      .level_o (sda_level),
      .rise_o  (sda_rise),
      .fall_o  (sda_fall)
   );

   assign start_det = sda_fall & scl_level;
   assign stop_det  = sda_rise & scl_level;
   assign rx_byte   = {shift_q[6:0], sda_level};

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      tx_d         = tx_q;
      rw_d         = rw_q;
      phase_d      = phase_q;
      byte_lo_d    = byte_lo_q;
      sda_low_d    = sda_low_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      addr_match_d = addr_match_q;
      busy_d       = busy_q;

      if (stop_det) begin
         state_d      = IDLE;
         sda_low_d    = 1'b0;
         addr_match_d = 1'b0;
         busy_d       = 1'b0;
      end else if (start_det) begin
         state_d      = ADDR;
         bit_cnt_d    = '0;
         sda_low_d    = 1'b0;
         addr_match_d = 1'b0;
         busy_d       = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               sda_low_d = 1'b0;
            end

            ADDR: begin
               if (scl_rise) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (rx_byte[7:1] == SlaveAddress) begin
                        state_d      = ADDR_ACK;
                        rw_d         = rx_byte[0];
                        addr_match_d = 1'b1;
                        phase_d      = 1'b0;
                     end else begin
                        state_d   = WAIT_STOP;
                        sda_low_d = 1'b0;
                     end
                  end
               end
            end

            // phase_q: 0 = waiting for the fall that starts the ACK slot,
            // 1 = ACK on the bus, the next fall ends it.
            ADDR_ACK, WRITE_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     sda_low_d = (ACK == 1'b0);
                     phase_d   = 1'b1;
                  end else begin
                     phase_d   = 1'b0;
                     bit_cnt_d = '0;
                     if (state_q == WRITE_ACK || !rw_q) begin
                        state_d   = WRITE;
                        sda_low_d = 1'b0;
                     end else begin
                        state_d   = READ;
                        tx_d      = bus.TxData;
                        byte_lo_d = 1'b0;
                        sda_low_d = ~bus.TxData[15];
                     end
                  end
               end
            end

            WRITE: begin
               if (scl_rise) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rx_data_d  = rx_byte;
                     rx_valid_d = 1'b1;
                     state_d    = WRITE_ACK;
                     phase_d    = 1'b0;
                  end
               end
            end

            READ: begin
               if (scl_fall) begin
                  tx_d      = {tx_q[14:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d   = READ_ACK;
                     phase_d   = 1'b0;
                     sda_low_d = 1'b0;
                  end else begin
                     sda_low_d = ~tx_q[14];
                  end
               end
            end

            // After the low byte tx_q is exhausted, so the word is reloaded here.
            READ_ACK: begin
               if (scl_rise) begin
                  if (sda_level == NACK) begin
                     state_d = WAIT_STOP;
                  end else begin
                     phase_d = 1'b1;
                  end
               end else if (scl_fall && phase_q) begin
                  state_d   = READ;
                  phase_d   = 1'b0;
                  bit_cnt_d = '0;
                  if (byte_lo_q) begin
                     tx_d      = bus.TxData;
                     byte_lo_d = 1'b0;
                     sda_low_d = ~bus.TxData[15];
                  end else begin
                     byte_lo_d = 1'b1;
                     sda_low_d = ~tx_q[15];
                  end
               end
            end

            WAIT_STOP: begin
               sda_low_d = 1'b0;
            end

            default: begin
               state_d   = IDLE;
               sda_low_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         tx_q         <= '0;
         rw_q         <= 1'b0;
         phase_q      <= 1'b0;
         byte_lo_q    <= 1'b0;
         sda_low_q    <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         addr_match_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         tx_q         <= tx_d;
         rw_q         <= rw_d;
         phase_q      <= phase_d;
         byte_lo_q    <= byte_lo_d;
         sda_low_q    <= sda_low_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         addr_match_q <= addr_match_d;
         busy_q       <= busy_d;
      end
   end

   assign SDA           = sda_low_q ? 1'b0 : 1'bz;
   assign bus.RxData    = rx_data_q;
   assign bus.RxValid   = rx_valid_q;
   assign bus.AddrMatch = addr_match_q;
   assign bus.Busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-level bus master with randomized
// transfers checked against transaction-level expectations.
module tb_i2c_target;

   localparam int unsigned HALF = 20;
   localparam int unsigned QTR  = 8;
   localparam logic [6:0]  TGT  = 7'h49;

   logic clock = 1'b0;
   logic Reset;
   logic sda_drv_low;
   wire  SDA;

   pullup (SDA);
   assign SDA = sda_drv_low ? 1'b0 : 1'bz;

   i2c_target_if bus ();

   i2c_target #(.SlaveAddress(TGT)) dut (
      .clock (clock),
      .Reset (Reset),
      .SDA   (SDA),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   int unsigned rxv_cycles = 0;
   int unsigned rxv_edges  = 0;
   logic        rxv_prev   = 1'b0;

   always @(negedge clock) begin
      if (bus.RxValid === 1'b1) begin
         rxv_cycles++;
         if (rxv_prev !== 1'b1) rxv_edges++;
      end
      rxv_prev = bus.RxValid;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int unsigned n);
      repeat (n) @(negedge clock);
   endtask

   // One SCL period starting and ending with SCL low; b=1 releases SDA.
   task automatic bit_xfer(input logic b, output logic seen);
      wait_clk(QTR);
      sda_drv_low = ~b;
      wait_clk(QTR);
      bus.SCL = 1'b1;
      wait_clk(HALF / 2);
      seen = SDA;
      wait_clk(HALF / 2);
      bus.SCL = 1'b0;
   endtask

   task automatic bus_start();
      wait_clk(QTR);
      sda_drv_low = 1'b0;
      wait_clk(QTR);
      bus.SCL = 1'b1;
      wait_clk(HALF);
      sda_drv_low = 1'b1;
      wait_clk(HALF);
      bus.SCL = 1'b0;
   endtask

   task automatic bus_stop();
      wait_clk(QTR);
      sda_drv_low = 1'b1;
      wait_clk(QTR);
      bus.SCL = 1'b1;
      wait_clk(HALF);
      sda_drv_low = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
      bit_xfer(1'b1, ack);
   endtask

   task automatic read_byte(input logic master_nack, output logic [7:0] d);
      logic s;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         bit_xfer(1'b1, s);
         d = {d[6:0], s};
      end
      bit_xfer(master_nack, s);
   endtask

   int unsigned exp_rxv = 0;

   task automatic run_write(input logic [7:0] first, input int unsigned extra);
      logic ack;
      logic [7:0] d;
      bus_start();
      check_eq("busy_after_start", bus.Busy, 1'b1);
      write_byte({TGT, 1'b0}, ack);
      check_eq("wr_addr_ack", ack, 1'b0);
      check_eq("wr_addr_match", bus.AddrMatch, 1'b1);
      for (int unsigned i = 0; i <= extra; i++) begin
         d = (i == 0) ? first : 8'($urandom);
         write_byte(d, ack);
         exp_rxv++;
         check_eq("wr_data_ack", ack, 1'b0);
         check_eq("wr_rxdata", bus.RxData, d);
      end
      bus_stop();
      check_eq("wr_busy_after_stop", bus.Busy, 1'b0);
      check_eq("wr_match_after_stop", bus.AddrMatch, 1'b0);
      check_eq("rxvalid_pulses", rxv_edges, exp_rxv);
      check_eq("rxvalid_width", rxv_cycles, exp_rxv);
   endtask

   // Word model: TxData is latched at the address ACK and again after each low byte.
   task automatic run_read(input int unsigned nbytes, input logic [15:0] word0);
      logic ack;
      logic [7:0] got;
      logic [15:0] cur;
      bus.TxData = word0;
      cur = word0;
      bus_start();
      write_byte({TGT, 1'b1}, ack);
      check_eq("rd_addr_ack", ack, 1'b0);
      check_eq("rd_addr_match", bus.AddrMatch, 1'b1);
      for (int unsigned i = 0; i < nbytes; i++) begin
         read_byte(i == nbytes - 1, got);
         check_eq("rd_byte", got, (i % 2 == 0) ? cur[15:8] : cur[7:0]);
         if (i % 2 == 0) bus.TxData = 16'($urandom);
         else            cur = bus.TxData;
      end
      wait_clk(QTR / 2);
      check_eq("rd_released_after_nack", SDA, 1'b1);
      bus_stop();
      check_eq("rd_busy_after_stop", bus.Busy, 1'b0);
   endtask

   task automatic run_nomatch(input logic [6:0] addr);
      logic ack;
      bus_start();
      write_byte({addr, 1'b0}, ack);
      check_eq("nm_addr_nack", ack, 1'b1);
      check_eq("nm_addr_match", bus.AddrMatch, 1'b0);
      write_byte(8'($urandom), ack);
      check_eq("nm_data_nack", ack, 1'b1);
      check_eq("nm_busy", bus.Busy, 1'b1);
      bus_stop();
      check_eq("nm_no_rxvalid", rxv_edges, exp_rxv);
      check_eq("nm_busy_after_stop", bus.Busy, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ack, s, seen;
      logic [7:0] got;
      logic [15:0] w;
      logic [6:0] bad;

      Reset       = 1'b1;
      sda_drv_low = 1'b0;
      bus.SCL     = 1'b1;
      bus.TxData  = '0;
      wait_clk(5);
      Reset = 1'b0;
      wait_clk(5);

      check_eq("rst_sda", SDA, 1'b1);
      check_eq("rst_rxdata", bus.RxData, 8'h00);
      check_eq("rst_rxvalid", bus.RxValid, 1'b0);
      check_eq("rst_addrmatch", bus.AddrMatch, 1'b0);
      check_eq("rst_busy", bus.Busy, 1'b0);

      run_write(8'hA5, 0);
      run_write(8'($urandom), $urandom_range(1, 3));

      run_read(2, 16'h1A80);
      run_read($urandom_range(3, 6), 16'($urandom));

      run_nomatch(7'h48);
      bad = TGT + 7'($urandom_range(1, 127));
      run_nomatch(bad);

      // Write then repeated START into a read
      w = 16'($urandom);
      bus.TxData = w;
      bus_start();
      write_byte({TGT, 1'b0}, ack);
      write_byte(8'h11, ack);
      exp_rxv++;
      check_eq("rs_data_ack", ack, 1'b0);
      check_eq("rs_rxdata", bus.RxData, 8'h11);
      bus_start();
      check_eq("rs_match_cleared", bus.AddrMatch, 1'b0);
      check_eq("rs_busy", bus.Busy, 1'b1);
      write_byte({TGT, 1'b1}, ack);
      check_eq("rs_addr_ack", ack, 1'b0);
      read_byte(1'b1, got);
      check_eq("rs_read_hi", got, w[15:8]);
      bus_stop();
      check_eq("rs_rxdata_kept", bus.RxData, 8'h11);
      check_eq("rs_rxvalid_pulses", rxv_edges, exp_rxv);

      // Reset while the target is driving the address ACK
      bus_start();
      for (int i = 7; i >= 0; i--) bit_xfer((i == 0) ? 1'b1 : TGT[i - 1], s);
      wait_clk(6);
      check_eq("ack_driven", SDA, 1'b0);
      Reset = 1'b1;
      wait_clk(1);
      check_eq("rst_mid_sda", SDA, 1'b1);
      check_eq("rst_mid_busy", bus.Busy, 1'b0);
      check_eq("rst_mid_match", bus.AddrMatch, 1'b0);
      check_eq("rst_mid_rxdata", bus.RxData, 8'h00);
      check_eq("rst_mid_rxvalid", bus.RxValid, 1'b0);
      Reset = 1'b0;
      sda_drv_low = 1'b0;
      wait_clk(QTR);
      bus.SCL = 1'b1;
      wait_clk(HALF);

      // One-clock SDA glitch while SCL is high
      seen = 1'b0;
      sda_drv_low = 1'b1;
      wait_clk(1);
      sda_drv_low = 1'b0;
      for (int i = 0; i < 12; i++) begin
         wait_clk(1);
         if (bus.Busy === 1'b1) seen = 1'b1;
      end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
      check_eq("glitch_start_seen", seen, 1'b0);
`else
      check_eq("glitch_start_seen", seen, 1'b1);
`endif
      check_eq("glitch_busy_end", bus.Busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
